// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the write-back stage
package wb_pkg;

    // Result select driven by the decoder and carried down the pipe
    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_LINK = 2'b10,
        RES_IMM  = 2'b11
    } res_src_e;

    // Load size/sign; word types only differ from full on 64-bit datapaths
    typedef enum logic [2:0] {
        LD_FULL = 3'b000,
        LD_HS   = 3'b001,
        LD_HU   = 3'b010,
        LD_BS   = 3'b011,
        LD_BU   = 3'b100,
        LD_WS   = 3'b101,
        LD_WU   = 3'b110
    } load_type_e;

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half/word lane out of a read container and extends it
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int OFF_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [2:0]        type_i,
    output logic [DATA_W-1:0] data_o
);

    // Misaligned half/word offsets round down by masking the low offset bits
    localparam logic [OFF_W-1:0] H_MASK = ~OFF_W'(1);
    localparam logic [OFF_W-1:0] W_MASK = ~OFF_W'(3);

    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;

    assign b = 8'(data_i >> {off_i, 3'b000});
    assign h = 16'(data_i >> {off_i & H_MASK, 3'b000});
    assign w = 32'(data_i >> {off_i & W_MASK, 3'b000});

    // Extend the selected lane; word loads fall back to full width on 32-bit builds
    always_comb begin
        data_o = data_i;
        case (type_i)
            LD_HS:   data_o = DATA_W'($signed(h));
            LD_HU:   data_o = DATA_W'(h);
            LD_BS:   data_o = DATA_W'($signed(b));
            LD_BU:   data_o = DATA_W'(b);
            LD_WS:   data_o = (DATA_W == 64) ? DATA_W'($signed(w)) : data_i;
            LD_WU:   data_o = (DATA_W == 64) ? DATA_W'(w) : data_i;
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_gen2.sv
// wb_stage_gen2: MEM/WB pipeline register with result select, load extraction and retire counter
module wb_stage_gen2
    import wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic              StallW,
    input  logic              FlushW,
    input  logic              ValidM,
    input  logic              RegWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [2:0]        LoadTypeM,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [DATA_W-1:0] RD,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] PCPlus4M,
    input  logic [DATA_W-1:0] ImmM,
    output logic [DATA_W-1:0] ResultW,
    output logic [REG_AW-1:0] WriteRegW,
    output logic              RegWriteW,
    output logic              ValidW,
    output logic [CNT_W-1:0]  InstRetW
);

    localparam int OFF_W = $clog2(DATA_W / 8);

    logic              valid_q, valid_d;
    logic              regwrite_q, regwrite_d;
    logic [REG_AW-1:0] wreg_q, wreg_d;
    logic [1:0]        src_q, src_d;
    logic [2:0]        lt_q, lt_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] load_data;

    // Next WB slot: flush inserts a cleared bubble, stall holds, otherwise capture MEM
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        wreg_d     = wreg_q;
        src_d      = src_q;
        lt_d       = lt_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        if (FlushW) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            wreg_d     = '0;
            src_d      = '0;
            lt_d       = '0;
            rd_d       = '0;
            alu_d      = '0;
            pc_d       = '0;
            imm_d      = '0;
        end else if (!StallW) begin
            valid_d    = ValidM;
            regwrite_d = RegWriteM;
            wreg_d     = WriteRegM;
            src_d      = ResultSrcM;
            lt_d       = LoadTypeM;
            rd_d       = RD;
            alu_d      = ALUOutM;
            pc_d       = PCPlus4M;
            imm_d      = ImmM;
        end
    end

    // A valid slot retires whenever it leaves WB, even when it is leaving because of a flush
    always_comb cnt_d = cnt_q + CNT_W'(valid_q && !StallW);

    // WB state register and retire counter
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            src_q      <= '0;
            lt_q       <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            src_q      <= src_d;
            lt_q       <= lt_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            cnt_q      <= cnt_d;
        end
    end

    load_align #(.DATA_W(DATA_W)) u_align (
        .data_i (rd_q),
        .off_i  (alu_q[OFF_W-1:0]),
        .type_i (lt_q),
        .data_o (load_data)
    );

    assign ResultW   = (src_q == RES_ALU)  ? alu_q :
                       (src_q == RES_MEM)  ? load_data :
                       (src_q == RES_LINK) ? pc_q : imm_q;
    assign WriteRegW = wreg_q;
    assign ValidW    = valid_q;
    assign RegWriteW = regwrite_q && valid_q && !(ZERO_REG && wreg_q == '0);
    assign InstRetW  = cnt_q;

endmodule

// File: tb/tb_wb_stage_gen2.sv
// tb_wb_stage_gen2: checks a 32-bit/CNT_W=4/ZERO_REG=1 and a 64-bit/ZERO_REG=0 build against a reference model
module tb_wb_stage_gen2;

    logic        Clk = 1'b0;
    logic        rst = 1'b0;
    logic        StallW = 0, FlushW = 0, ValidM = 0, RegWriteM = 0;
    logic [1:0]  ResultSrcM = 0;
    logic [2:0]  LoadTypeM = 0;
    logic [4:0]  WriteRegM = 0;
    logic [63:0] RD = 0, ALUOutM = 0, PCPlus4M = 0, ImmM = 0;

    logic [31:0] r0;
    logic [63:0] r1;
    logic [4:0]  wr0, wr1;
    logic        rw0, rw1, v0, v1;
    logic [3:0]  ir0;
    logic [31:0] ir1;

    int checks = 0;
    int failures = 0;

    logic        m_v, m_rw;
    logic [4:0]  m_wr;
    logic [1:0]  m_src;
    logic [2:0]  m_lt;
    logic [63:0] m_rd, m_alu, m_pc, m_imm;
    int unsigned m_cnt;

    always #5 Clk = ~Clk;

    wb_stage_gen2 #(.DATA_W(32), .REG_AW(5), .CNT_W(4), .ZERO_REG(1'b1)) dut0 (
        .Clk(Clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM),
        .WriteRegM(WriteRegM), .RD(RD[31:0]), .ALUOutM(ALUOutM[31:0]),
        .PCPlus4M(PCPlus4M[31:0]), .ImmM(ImmM[31:0]), .ResultW(r0),
        .WriteRegW(wr0), .RegWriteW(rw0), .ValidW(v0), .InstRetW(ir0)
    );

    wb_stage_gen2 #(.DATA_W(64), .REG_AW(5), .CNT_W(32), .ZERO_REG(1'b0)) dut1 (
        .Clk(Clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM),
        .WriteRegM(WriteRegM), .RD(RD), .ALUOutM(ALUOutM),
        .PCPlus4M(PCPlus4M), .ImmM(ImmM), .ResultW(r1),
        .WriteRegW(wr1), .RegWriteW(rw1), .ValidW(v1), .InstRetW(ir1)
    );

    function automatic logic [63:0] mask_w(int w);
        return (w == 32) ? 64'hFFFF_FFFF : '1;
    endfunction

    // Load extraction from the rules: pick lane, round offset down, extend
    function automatic logic [63:0] ld_ref(logic [63:0] rd, logic [63:0] alu, logic [2:0] lt, int w);
        int off = int'(alu % ((w == 32) ? 4 : 8));
        int bits = w;
        logic sgn = 1'b0;
        logic [63:0] m, v;
        case (lt)
            3'd1, 3'd2: begin bits = 16; off = off - off % 2; sgn = (lt == 3'd1); end
            3'd3, 3'd4: begin bits = 8; sgn = (lt == 3'd3); end
            3'd5, 3'd6: if (w == 64) begin bits = 32; off = off - off % 4; sgn = (lt == 3'd5); end
                        else off = 0;
            default: off = 0;
        endcase
        m = (bits == 64) ? '1 : ((64'd1 << bits) - 1);
        v = (rd >> (off * 8)) & m;
        if (sgn && v[bits-1]) v = v | ~m;
        return v & mask_w(w);
    endfunction

    function automatic logic [63:0] res_ref(int w);
        case (m_src)
            2'd0: return m_alu & mask_w(w);
            2'd1: return ld_ref(m_rd, m_alu, m_lt, w);
            2'd2: return m_pc & mask_w(w);
            default: return m_imm & mask_w(w);
        endcase
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_v = 0; m_rw = 0; m_wr = 0; m_src = 0; m_lt = 0;
        m_rd = 0; m_alu = 0; m_pc = 0; m_imm = 0; m_cnt = 0;
    endtask

    task automatic compare_all();
        chk("valid0", 64'(v0), 64'(m_v));
        chk("valid1", 64'(v1), 64'(m_v));
        chk("regwr0", 64'(rw0), 64'(m_rw && m_v && m_wr != 0));
        chk("regwr1", 64'(rw1), 64'(m_rw && m_v));
        chk("instret0", 64'(ir0), 64'(m_cnt % 16));
        chk("instret1", 64'(ir1), 64'(32'(m_cnt)));
        if (m_v) begin
            chk("result0", 64'(r0), res_ref(32));
            chk("result1", r1, res_ref(64));
            chk("wreg0", 64'(wr0), 64'(m_wr));
            chk("wreg1", 64'(wr1), 64'(m_wr));
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare
    task automatic cyc();
        @(posedge Clk);
        if (rst) begin
            if (m_v && !StallW) m_cnt++;
            if (FlushW) begin
                m_v = 0; m_rw = 0;
            end else if (!StallW) begin
                m_v = ValidM; m_rw = RegWriteM; m_wr = WriteRegM; m_src = ResultSrcM;
                m_lt = LoadTypeM; m_rd = RD; m_alu = ALUOutM; m_pc = PCPlus4M; m_imm = ImmM;
            end
        end
        #1;
        compare_all();
    endtask

    task automatic set_m(logic v, logic rw, logic [4:0] wr, logic [1:0] src, logic [2:0] lt,
                         logic [63:0] rd, logic [63:0] alu, logic [63:0] pc, logic [63:0] imm);
        ValidM = v; RegWriteM = rw; WriteRegM = wr; ResultSrcM = src; LoadTypeM = lt;
        RD = rd; ALUOutM = alu; PCPlus4M = pc; ImmM = imm;
    endtask

    typedef struct {
        logic [2:0]  lt;
        logic [63:0] off;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];
    logic [31:0] saved_r;
    logic [3:0]  saved_ir0;
    logic [31:0] saved_ir1;

    initial begin
        vecs[0] = '{3'd3, 64'd0, 32'h0000_0001};
        vecs[1] = '{3'd3, 64'd1, 32'h0000_007F};
        vecs[2] = '{3'd3, 64'd2, 32'hFFFF_FFFF};
        vecs[3] = '{3'd3, 64'd3, 32'hFFFF_FF80};
        vecs[4] = '{3'd2, 64'd2, 32'h0000_80FF};
        vecs[5] = '{3'd1, 64'd3, 32'hFFFF_80FF};

        model_reset();
        set_m(1, 1, 5'd7, 2'd0, 3'd0, 64'hAA, 64'h55, 64'h4, 64'h9);
        repeat (2) @(posedge Clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_valid", 64'(v0), 0);
        chk("rst_regwr", 64'(rw0), 0);
        chk("rst_wreg", 64'(wr0), 0);
        chk("rst_result", 64'(r0), 0);
        chk("rst_instret", 64'(ir1), 0);

        set_m(1, 1, 5'd5, 2'd0, 3'd0, 64'h0, 64'h1234, 64'h0, 64'h0);
        cyc();
        chk("first_result", 64'(r0), 64'h1234);
        chk("first_regwr", 64'(rw0), 1);
        chk("first_wreg", 64'(wr0), 5);

        for (int i = 0; i < 6; i++) begin
            set_m(1, 1, 5'd3, 2'd1, vecs[i].lt, 64'h80FF_7F01, vecs[i].off, 64'h0, 64'h0);
            cyc();
            chk($sformatf("load_vec%0d", i), 64'(r0), 64'(vecs[i].exp));
        end

        set_m(1, 1, 5'd9, 2'd2, 3'd0, 64'h0, 64'h0, 64'hCAFE_0004, 64'h0);
        cyc();
        saved_r = r0;
        saved_ir1 = ir1;
        StallW = 1;
        for (int i = 0; i < 3; i++) begin
            set_m(1, 1, 5'(i + 10), 2'd3, 3'd0, 64'h0, 64'h0, 64'h0, 64'(i + 100));
            cyc();
            chk("stall_hold", 64'(r0), 64'(saved_r));
            chk("stall_cnt", 64'(ir1), 64'(saved_ir1));
        end
        StallW = 0;
        cyc();
        chk("stall_release", 64'(r0), 64'd102);

        StallW = 1; FlushW = 1;
        saved_ir1 = ir1;
        cyc();
        chk("flushstall_valid", 64'(v0), 0);
        chk("flushstall_cnt", 64'(ir1), 64'(saved_ir1));
        StallW = 0; FlushW = 0;
        cyc();
        FlushW = 1;
        saved_ir1 = ir1;
        cyc();
        chk("flush_cnt", 64'(ir1), 64'(saved_ir1 + 1));
        chk("flush_valid", 64'(v0), 0);
        FlushW = 0;

        set_m(1, 1, 5'd0, 2'd0, 3'd0, 64'h0, 64'h77, 64'h0, 64'h0);
        cyc();
        chk("zero_reg_on", 64'(rw0), 0);
        chk("zero_reg_off", 64'(rw1), 1);

        rst = 0;
        #2;
        rst = 1;
        model_reset();
        set_m(1, 1, 5'd1, 2'd0, 3'd0, 64'h0, 64'h1, 64'h0, 64'h0);
        repeat (18) cyc();
        chk("wrap_cnt4", 64'(ir0), 1);
        chk("wrap_cnt32", 64'(ir1), 17);

        StallW = 1;
        cyc();
        #2;
        rst = 0;
        #1;
        chk("async_rst_cnt", 64'(ir0), 0);
        chk("async_rst_valid", 64'(v0), 0);
        chk("async_rst_cnt1", 64'(ir1), 0);
        model_reset();
        @(negedge Clk);
        rst = 1;
        StallW = 0;
        set_m(1, 1, 5'd4, 2'd3, 3'd0, 64'h0, 64'h0, 64'h0, 64'h3C);
        cyc();
        chk("post_rst_capture", 64'(r0), 64'h3C);

        for (int i = 0; i < 400; i++) begin
            StallW = ($urandom_range(0, 4) == 0);
            FlushW = ($urandom_range(0, 6) == 0);
            set_m(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                  2'($urandom), 3'($urandom_range(0, 6)), {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage_gen2.md
Name: wb_stage_gen2

Overview:
Parametrised write-back stage: the MEM/WB pipeline register plus result selection, extended with stall/flush control, sub-word load extraction and a retired-instruction counter. Sits between the memory stage and the register file. Drives the register-file write port and the WB-to-EX forwarding path.

Parameters:
DATA_W, 32, datapath width; legal values are 32 or 64.
REG_AW, 5, register-address width.
CNT_W, 32, width of the retired-instruction counter.
ZERO_REG, 1, if 1 then register 0 is hardwired and writes to it are suppressed.

Ports:
Clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low
StallW  in  1  hold the WB register contents
FlushW  in  1  insert a bubble into the WB register
ValidM  in  1  the MEM-stage slot holds a real instruction
RegWriteM  in  1  register-write enable from MEM
ResultSrcM  in  2  result select: 00 ALU, 01 memory, 10 link (PC+4), 11 immediate
LoadTypeM  in  3  load type: 000 full, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned, 101 word signed, 110 word unsigned
WriteRegM  in  REG_AW  destination register
RD  in  DATA_W  raw memory read data (aligned container)
ALUOutM  in  DATA_W  ALU result or address
PCPlus4M  in  DATA_W  link value
ImmM  in  DATA_W  immediate result
ResultW  out  DATA_W  write-back data
WriteRegW  out  REG_AW  write-back register address
RegWriteW  out  1  qualified register-file write enable
ValidW  out  1  the WB slot holds a real instruction
InstRetW  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=0, asynchronous): every WB register clears. Outputs: ValidW=0, RegWriteW=0, WriteRegW=0, ResultW=0, InstRetW=0.
- Register update, on each rising edge of Clk, with priority FlushW > StallW > load:
  - FlushW=1: ValidW and the internal RegWrite bit clear. Data fields do not care (they are cleared in the implementation).
  - StallW=1: hold all fields.
  - Otherwise: capture all M inputs.
- Latency: one cycle from M inputs to W outputs. ResultW is combinational from the registered fields; there is no extra cycle.
- Memory path:
  - Byte offset is ALUOutW[OFF-1:0], where OFF = log2(DATA_W/8).
  - Half uses offset bit 1 and up; word (64-bit builds only) uses offset bit 2.
  - The selected lane is right-justified, then sign- or zero-extended to DATA_W according to LoadTypeW.
  - Misaligned half or word offsets: the low offset bits are ignored, i.e. the access is rounded down. No trap.
  - Load types 101 and 110 with DATA_W=32 behave as 000.
- ResultW mux:
  - 00 gives ALUOutW.
  - 01 gives the extracted load data.
  - 10 gives PCPlus4W.
  - 11 gives ImmW.
- RegWriteW = internal RegWrite AND ValidW AND NOT (ZERO_REG AND WriteRegW==0).
- InstRetW:
  - Increments by 1 on each rising edge where ValidW=1 and StallW=0, i.e. when the slot retires.
  - Wraps modulo 2^CNT_W.
  - A slot that is flushed while valid still retires on that edge, because the retirement is counted before it is replaced.
  - Cleared only by reset.
- Simultaneous StallW and FlushW: flush wins, and the counter still counts when ValidW=1 and StallW=0. Because StallW=1 in this case, there is no count.
- Reset asserted mid-stall clears everything immediately. The first edge after deassertion captures the M inputs normally.

Decomposition:
- Shared package wb_pkg holds:
  - the ResultSrc encodings: RES_ALU, RES_MEM, RES_LINK, RES_IMM;
  - the LoadType encodings: LD_FULL, LD_HS, LD_HU, LD_BS, LD_BU, LD_WS, LD_WU.
- One sub-module, load_align, is combinational. Inputs are DATA_W data, the offset and the load type; output is the extended data.
- The pipeline register, mux and counter stay in the top level.

Test Plan:
- Reset with valid inputs present, then release rst → all outputs are 0. First edge with ValidM=1, RegWriteM=1, WriteRegM=5, ALUOutM=0x1234, ResultSrc=00 → next cycle ResultW=0x1234, RegWriteW=1, WriteRegW=5.
- Byte and half loads with RD=0x80FF7F01 (DATA_W=32), cycling LoadType:
  - byte-signed at offsets 0..3 → 0x01, 0x7F, 0xFFFFFFFF, 0xFFFFFF80;
  - half-unsigned at offset 2 → 0x000080FF;
  - half-signed at offset 3 → 0xFFFF80FF (offset rounded down).
- Stall for 3 cycles while the M inputs change → W outputs held constant and InstRetW frozen. After release, the M values from the cycle before release appear.
- FlushW=1 with StallW=1 and ValidW=1 → next cycle ValidW=0, RegWriteW=0, InstRetW unchanged. Flush alone while valid → InstRetW +1 and ValidW=0.
- WriteRegM=0, RegWriteM=1, ZERO_REG=1 → RegWriteW=0. The same stimulus with ZERO_REG=0 → RegWriteW=1.
- CNT_W=4: retire 17 valid instructions → InstRetW=1 (wrap). Assert rst asynchronously between edges → InstRetW goes to 0 immediately.
